// File: rtl/pkt_pkg.sv
// ============================================================================
// pkt_pkg: shared types and constants for the packet capture block.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pkt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HANDOFF = 2'd2,
    DROP    = 2'd3
  } state_e;

  localparam logic [31:0] WORD_BYTES     = 32'd4;
  localparam int          CTRL_LEN_LSB   = 0;
  localparam int          CTRL_SEQ_LSB   = 16;
  localparam int          CTRL_VALID_BIT = 31;

  function automatic logic [31:0] make_control(input logic [7:0] seq, input logic [15:0] len);
    logic [31:0] c;
    c                         = '0;
    c[CTRL_VALID_BIT]         = 1'b1;
    c[CTRL_SEQ_LSB +: 8]      = seq;
    c[CTRL_LEN_LSB +: 16]     = len;
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ring_addr.sv
// ============================================================================
// ring_addr: ring-buffer address helpers (start-of-packet wrap, end address,
// write-pointer advance). Purely combinational. Revision: 1.0
// ============================================================================
`default_nettype none

module ring_addr
  import pkt_pkg::*;
#(
  parameter logic [31:0] BUF_BASE      = 32'h0000_0000,
  parameter logic [31:0] BUF_SIZE      = 32'h0001_0000,
  parameter logic [15:0] MAX_PKT_WORDS = 16'd512
) (
  input  logic [31:0] wr_ptr_i,
  input  logic [31:0] begin_i,
  input  logic [15:0] words_i,
  input  logic [31:0] end_i,
  output logic [31:0] sop_addr_o,
  output logic [31:0] end_addr_o,
  output logic [31:0] next_ptr_o
);

  // 33-bit so a ring ending at the top of the address space cannot overflow.
  localparam logic [32:0] RING_TOP  = {1'b0, BUF_BASE} + {1'b0, BUF_SIZE};
  localparam logic [32:0] MAX_BYTES = {17'b0, MAX_PKT_WORDS} * {1'b0, WORD_BYTES};

  assign sop_addr_o = (({1'b0, wr_ptr_i} + MAX_BYTES) > RING_TOP) ? BUF_BASE : wr_ptr_i;
  assign end_addr_o = begin_i + ({16'b0, words_i} * WORD_BYTES);
  assign next_ptr_o = ({1'b0, end_i} == RING_TOP) ? BUF_BASE : end_i;

endmodule

`default_nettype wire

// File: rtl/pkt_capture.sv
// ============================================================================
// pkt_capture: streams packets into a FIFO and hands a descriptor to a
// host ring-buffer writer. Revision: 1.0
// ============================================================================
`default_nettype none

module pkt_capture
  import pkt_pkg::*;
#(
  parameter logic [31:0] BUF_BASE      = 32'h0000_0000,
  parameter logic [31:0] BUF_SIZE      = 32'h0001_0000,
  parameter logic [15:0] MAX_PKT_WORDS = 16'd512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [1:0]  in_empty,
  output logic        in_ready,
  output logic [31:0] fifo_in,
  output logic        fifo_wr,
  input  logic        fifo_full,
  output logic        wr_ctrl,
  input  logic        wr_ctrl_rdy,
  output logic [31:0] control,
  output logic [31:0] pkt_begin,
  output logic [31:0] pkt_end,
  output logic [15:0] drop_count
);

  state_e      state_q, state_d;
  logic [31:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]  seq_q, seq_d;
  logic [15:0] drop_q, drop_d;
  logic [15:0] words_q, words_d;
  logic [31:0] fifo_in_q, fifo_in_d;
  logic        fifo_wr_q, fifo_wr_d;
  logic        wr_ctrl_q, wr_ctrl_d;
  logic [31:0] control_q, control_d;
  logic [31:0] pkt_begin_q, pkt_begin_d;
  logic [31:0] pkt_end_q, pkt_end_d;

  logic        accept, start_pkt, over_limit, keep_word, close_pkt, drop_pkt;
  logic [15:0] words_nxt, len;
  logic [31:0] sop_addr, end_addr, next_ptr, begin_sel;

  assign in_ready = ((state_q == IDLE || state_q == CAPTURE) && !fifo_full) || (state_q == DROP);
  assign accept   = in_valid && in_ready;

  // A sop in CAPTURE abandons the current packet and restarts on this word.
  assign start_pkt  = accept && in_sop && (state_q == IDLE || state_q == CAPTURE);
  assign over_limit = accept && !in_sop && (state_q == CAPTURE) && (words_q >= MAX_PKT_WORDS);
  assign keep_word  = accept && !in_sop && (state_q == CAPTURE) && !over_limit;
  assign close_pkt  = (start_pkt || keep_word) && in_eop;
  assign drop_pkt   = (start_pkt && state_q == CAPTURE) || over_limit;
  assign words_nxt  = start_pkt ? 16'd1 : words_q + 16'd1;
  assign len        = words_nxt * WORD_BYTES[15:0] - {14'b0, in_empty};
  assign begin_sel  = start_pkt ? sop_addr : pkt_begin_q;

  ring_addr #(
    .BUF_BASE      (BUF_BASE),
    .BUF_SIZE      (BUF_SIZE),
    .MAX_PKT_WORDS (MAX_PKT_WORDS)
  ) u_ring_addr (
    .wr_ptr_i   (wr_ptr_q),
    .begin_i    (begin_sel),
    .words_i    (words_nxt),
    .end_i      (pkt_end_q),
    .sop_addr_o (sop_addr),
    .end_addr_o (end_addr),
    .next_ptr_o (next_ptr)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    seq_d       = seq_q;
    drop_d      = drop_q;
    words_d     = words_q;
    fifo_in_d   = fifo_in_q;
    fifo_wr_d   = 1'b0;
    wr_ctrl_d   = 1'b0;
    control_d   = control_q;
    pkt_begin_d = pkt_begin_q;
    pkt_end_d   = pkt_end_q;

    if (drop_pkt && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;

    case (state_q)
      HANDOFF: if (wr_ctrl_rdy) begin
        state_d  = IDLE;
        wr_ptr_d = next_ptr;
        seq_d    = seq_q + 8'd1;
      end
      DROP:    if (accept && in_eop) state_d = IDLE;
      // The overflowing word may itself end the packet; then nothing is left to discard.
      CAPTURE: if (over_limit) state_d = in_eop ? IDLE : DROP;
      default: ;
    endcase

    if (start_pkt) begin
      pkt_begin_d = sop_addr;
      wr_ptr_d    = sop_addr;
      state_d     = CAPTURE;
    end
    if (start_pkt || keep_word) begin
      fifo_wr_d = 1'b1;
      fifo_in_d = in_data;
      words_d   = words_nxt;
    end
    if (close_pkt) begin
      state_d   = HANDOFF;
      pkt_end_d = end_addr;
      control_d = make_control(seq_q, len);
      wr_ctrl_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= BUF_BASE;
      seq_q       <= 8'd0;
      drop_q      <= 16'd0;
      words_q     <= 16'd0;
      fifo_in_q   <= 32'd0;
      fifo_wr_q   <= 1'b0;
      wr_ctrl_q   <= 1'b0;
      control_q   <= 32'd0;
      pkt_begin_q <= 32'd0;
      pkt_end_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      seq_q       <= seq_d;
      drop_q      <= drop_d;
      words_q     <= words_d;
      fifo_in_q   <= fifo_in_d;
      fifo_wr_q   <= fifo_wr_d;
      wr_ctrl_q   <= wr_ctrl_d;
      control_q   <= control_d;
      pkt_begin_q <= pkt_begin_d;
      pkt_end_q   <= pkt_end_d;
    end
  end

  assign fifo_in    = fifo_in_q;
  assign fifo_wr    = fifo_wr_q;
  assign wr_ctrl    = wr_ctrl_q;
  assign control    = control_q;
  assign pkt_begin  = pkt_begin_q;
  assign pkt_end    = pkt_end_q;
  assign drop_count = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_pkt_capture.sv
// ============================================================================
// tb_pkt_capture: directed stimulus with a packet-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pkt_capture;

  localparam logic [31:0] BASE = 32'd0;
  localparam logic [31:0] SIZE = 32'd128;
  localparam logic [15:0] MAXW = 16'd8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [1:0]  in_empty = '0;
  logic        in_ready;
  logic [31:0] fifo_in;
  logic        fifo_wr;
  logic        fifo_full = 1'b0;
  logic        wr_ctrl;
  logic        wr_ctrl_rdy = 1'b0;
  logic [31:0] control, pkt_begin, pkt_end;
  logic [15:0] drop_count;

  pkt_capture #(.BUF_BASE(BASE), .BUF_SIZE(SIZE), .MAX_PKT_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .in_eop(in_eop), .in_empty(in_empty), .in_ready(in_ready), .fifo_in(fifo_in),
    .fifo_wr(fifo_wr), .fifo_full(fifo_full), .wr_ctrl(wr_ctrl), .wr_ctrl_rdy(wr_ctrl_rdy),
    .control(control), .pkt_begin(pkt_begin), .pkt_end(pkt_end), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (packet-level rules) ----------------
  logic [31:0] exp_fifo[$];
  logic [31:0] m_ptr = BASE, m_begin = 0, m_end = 0, m_ctrl = 0;
  logic [7:0]  m_seq = 0;
  logic [15:0] m_drop = 0;
  int          m_words = 0;
  bit          m_in_pkt = 0, m_dropping = 0, m_wait = 0, m_ctrl_due = 0, m_rdy;

  task model_clear();
    exp_fifo.delete();
    m_ptr = BASE; m_seq = 0; m_drop = 0; m_words = 0;
    m_in_pkt = 0; m_dropping = 0; m_wait = 0; m_ctrl_due = 0;
  endtask

  task model_drop();
    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
  endtask

  task model_take();
    exp_fifo.push_back(in_data);
    m_words++;
    if (in_eop) begin
      m_end      = m_begin + 32'(4 * m_words);
      m_ctrl     = {1'b1, 7'd0, m_seq, 16'(4 * m_words - int'(in_empty))};
      m_wait     = 1;
      m_in_pkt   = 0;
      m_ctrl_due = 1;
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_clear();
    else begin
      m_rdy      = !m_wait && (m_dropping || !fifo_full);
      m_ctrl_due = 0;
      if (m_wait) begin
        if (wr_ctrl_rdy) begin
          m_wait = 0;
          m_ptr  = (m_end == BASE + SIZE) ? BASE : m_end;
          m_seq  = m_seq + 8'd1;
        end
      end else if (in_valid && m_rdy) begin
        if (m_dropping) begin
          if (in_eop) m_dropping = 0;
        end else if (in_sop) begin
          if (m_in_pkt) model_drop();
          if (longint'(m_ptr) + 4 * longint'(MAXW) > longint'(BASE) + longint'(SIZE)) m_ptr = BASE;
          m_begin = m_ptr; m_words = 0; m_in_pkt = 1;
          model_take();
        end else if (m_in_pkt) begin
          if (m_words == int'(MAXW)) begin
            model_drop();
            m_in_pkt   = 0;
            m_dropping = !in_eop;
          end else model_take();
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int cnt_wr = 0, cnt_ctrl = 0;
  logic [31:0] exp_word;

  always @(negedge clk) begin
    if (reset) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, !m_wait && (m_dropping || !fifo_full)});
      chk("wr_ctrl", {31'd0, wr_ctrl}, {31'd0, m_ctrl_due});
      chk("drop_count", {16'd0, drop_count}, {16'd0, m_drop});
      if (wr_ctrl) cnt_ctrl++;
      if (fifo_wr) begin
        cnt_wr++;
        if (exp_fifo.size() == 0) chk("fifo_wr_unexpected", 32'd1, 32'd0);
        else begin
          exp_word = exp_fifo.pop_front();
          chk("fifo_in", fifo_in, exp_word);
        end
      end
      if (m_wait) begin
        chk("pkt_begin", pkt_begin, m_begin);
        chk("pkt_end", pkt_end, m_end);
        chk("control", control, m_ctrl);
      end
    end
  end

  // ---------------- stimulus ----------------
  int stall_lows = 0;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input bit sop, input bit eop, input logic [1:0] emp);
    bit done;
    done = 0;
    in_data = d; in_valid = 1'b1; in_sop = sop; in_eop = eop; in_empty = emp;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
    end
    if (!done) chk("beat_accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [1:0] emp, input logic [31:0] tag,
                          input int stall_at, input bit with_eop);
    for (int k = 0; k < n; k++) begin
      if (k == stall_at) begin
        in_data = tag + 32'(k); in_valid = 1'b1; in_sop = (k == 0); in_eop = 1'b0;
        fifo_full = 1'b1;
        stall_lows = 0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          if (!in_ready) stall_lows++;
          @(posedge clk); #1;
        end
        fifo_full = 1'b0;
      end
      beat(tag + 32'(k), k == 0, with_eop && (k == n - 1), emp);
    end
  endtask

  task automatic wait_ctrl();
    bit seen;
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = wr_ctrl;
    end
    chk("wr_ctrl_seen", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    cycles(2);
  endtask

  task automatic release_writer();
    wr_ctrl_rdy = 1'b1;
    cycles(1);
    wr_ctrl_rdy = 1'b0;
    cycles(1);
  endtask

  task automatic pkt_and_release(input int n, input logic [1:0] emp, input logic [31:0] tag);
    send_pkt(n, emp, tag, -1, 1'b1);
    wait_ctrl();
    release_writer();
  endtask

  task automatic check_reset_vals();
    chk("rst_fifo_wr", {31'd0, fifo_wr}, 32'd0);
    chk("rst_fifo_in", fifo_in, 32'd0);
    chk("rst_wr_ctrl", {31'd0, wr_ctrl}, 32'd0);
    chk("rst_control", control, 32'd0);
    chk("rst_pkt_begin", pkt_begin, 32'd0);
    chk("rst_pkt_end", pkt_end, 32'd0);
    chk("rst_drop_count", {16'd0, drop_count}, 32'd0);
  endtask

  initial begin
    cycles(3);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    reset = 1'b1;
    cycles(2);

    // Stray writer-done pulse and a non-sop word in IDLE must both be ignored.
    release_writer();
    beat(32'hDEAD_0000, 1'b0, 1'b0, 2'd0);
    cycles(2);
    chk("stray_no_write", 32'(cnt_wr), 32'd0);

    // 4 words, empty 2
    send_pkt(4, 2'd2, 32'hA000_0000, -1, 1'b1);
    wait_ctrl();
    chk("A_cnt_wr", 32'(cnt_wr), 32'd4);
    chk("A_cnt_ctrl", 32'(cnt_ctrl), 32'd1);
    chk("A_begin", pkt_begin, 32'd0);
    chk("A_end", pkt_end, 32'd16);
    chk("A_control", control, 32'h8000_000E);
    release_writer();

    send_pkt(3, 2'd0, 32'hB000_0000, -1, 1'b1);
    wait_ctrl();
    chk("B_begin", pkt_begin, 32'd16);
    chk("B_end", pkt_end, 32'd28);
    chk("B_control", control, 32'h8001_000C);
    release_writer();

    // FIFO backpressure for three cycles mid-packet
    send_pkt(6, 2'd1, 32'hC000_0000, 3, 1'b1);
    wait_ctrl();
    chk("C_stall_lows", 32'(stall_lows), 32'd3);
    chk("C_begin", pkt_begin, 32'd28);
    chk("C_control", control, 32'h8002_0017);
    release_writer();

    // Oversize packets: MAX+1 words, then a longer one that goes through DROP
    send_pkt(9, 2'd0, 32'hD000_0000, -1, 1'b1);
    cycles(3);
    chk("D_cnt_wr", 32'(cnt_wr), 32'd21);
    chk("D_cnt_ctrl", 32'(cnt_ctrl), 32'd3);
    chk("D_drop", {16'd0, drop_count}, 32'd1);
    send_pkt(11, 2'd0, 32'hE000_0000, -1, 1'b1);
    cycles(3);
    chk("E_cnt_wr", 32'(cnt_wr), 32'd29);
    chk("E_drop", {16'd0, drop_count}, 32'd2);

    // Walk the pointer to 120, then a sop must wrap to the base.
    pkt_and_release(4, 2'd0, 32'hF000_0000);
    pkt_and_release(7, 2'd0, 32'hF100_0000);
    pkt_and_release(6, 2'd0, 32'hF200_0000);
    send_pkt(2, 2'd0, 32'hF300_0000, -1, 1'b1);
    wait_ctrl();
    chk("wrap_begin", pkt_begin, 32'd0);
    chk("wrap_control", control, 32'h8006_0008);
    release_writer();

    // Packet ending exactly at the ring top
    pkt_and_release(8, 2'd0, 32'hF400_0000);
    pkt_and_release(8, 2'd0, 32'hF500_0000);
    pkt_and_release(6, 2'd0, 32'hF600_0000);
    send_pkt(8, 2'd0, 32'hF700_0000, -1, 1'b1);
    wait_ctrl();
    chk("top_begin", pkt_begin, 32'd96);
    chk("top_end", pkt_end, 32'd128);
    release_writer();
    send_pkt(1, 2'd3, 32'h1111_0000, -1, 1'b1);
    wait_ctrl();
    chk("single_begin", pkt_begin, 32'd0);
    chk("single_end", pkt_end, 32'd4);
    chk("single_control", control, 32'h800B_0001);
    release_writer();

    // sop arriving before eop restarts the packet
    send_pkt(3, 2'd0, 32'h2222_0000, -1, 1'b0);
    send_pkt(2, 2'd0, 32'h3333_0000, -1, 1'b1);
    wait_ctrl();
    chk("restart_drop", {16'd0, drop_count}, 32'd3);
    chk("restart_begin", pkt_begin, 32'd4);
    chk("restart_control", control, 32'h800C_0008);
    release_writer();

    // Reset in the middle of a packet
    send_pkt(2, 2'd0, 32'h4444_0000, -1, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    reset = 1'b1;
    cycles(2);
    send_pkt(1, 2'd0, 32'h5555_0000, -1, 1'b1);
    wait_ctrl();
    chk("post_rst_begin", pkt_begin, 32'd0);
    chk("post_rst_end", pkt_end, 32'd4);
    chk("post_rst_control", control, 32'h8000_0004);
    release_writer();

    cycles(3);
    chk("fifo_queue_drained", 32'(exp_fifo.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
